// File: rtl/n64_flash_arbiter.sv
// Round-robin arbiter that funnels several flash requesters onto one Avalon-MM flash
// controller (CSR + data ports), with a read-timeout watchdog and per-port read windows.
module n64_flash_arbiter #(
    parameter int unsigned NUM_PORTS        = 2,
    parameter int unsigned CSR_BIT          = 27,
    parameter logic [7:0]  CSR_PORT_MASK    = 8'b10,
    parameter logic [7:0]  WINDOW_PORT_MASK = 8'b01,
    parameter logic [31:0] WINDOW_BASE      = 32'h1000_0000,
    parameter logic [31:0] WINDOW_SIZE      = 32'h0001_0000,
    parameter int unsigned TIMEOUT          = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_request,
    input  logic [NUM_PORTS-1:0]   req_write,
    input  logic [32*NUM_PORTS-1:0] req_address,
    input  logic [32*NUM_PORTS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]   req_ack,
    output logic [NUM_PORTS-1:0]   req_error,
    output logic [31:0]            req_rdata,
    output logic                   csr_addr,
    output logic                   csr_read,
    output logic                   csr_write,
    output logic [31:0]            csr_wdata,
    input  logic [31:0]            csr_rdata,
    output logic [29:0]            data_addr,
    output logic                   data_read,
    output logic                   data_write,
    output logic [31:0]            data_wdata,
    input  logic [31:0]            data_rdata,
    input  logic                   data_waitrequest,
    input  logic                   data_readdatavalid,
    output logic                   busy
);

    localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // 33-bit bounds so a window ending at the top of the address space cannot wrap.
    localparam logic [32:0] WinLo   = {1'b0, WINDOW_BASE};
    localparam logic [32:0] WinHi   = WinLo + {1'b0, WINDOW_SIZE};
    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);
    localparam logic [15:0] CntMax  = 16'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRead, StDone} state_e;

    state_e                 state_q;
    logic [IdxW-1:0]        rr_q;
    logic [NUM_PORTS-1:0]   grant_oh_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic                   write_q;
    logic                   csr_q;
    logic                   win_q;
    logic [15:0]            cnt_q;

    logic                   any_req;
    logic [NUM_PORTS-1:0]   sel_oh;
    logic [IdxW-1:0]        rr_next;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_wdata;
    logic                   sel_write;
    logic                   sel_csr;
    logic                   sel_win;
    logic                   in_window;
    logic                   rd_pass;

    // Two passes: first the ports at or after the pointer, then wrap to the lowest port.
    always_comb begin
        any_req   = 1'b0;
        sel_oh    = '0;
        rr_next   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        sel_csr   = 1'b0;
        sel_win   = 1'b0;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                if (!any_req && req_request[j] && (pass == 1 || j >= 32'(rr_q))) begin
                    any_req   = 1'b1;
                    sel_oh    = '0;
                    sel_oh[j] = 1'b1;
                    rr_next   = (j == NUM_PORTS - 1) ? '0 : IdxW'(j + 1);
                    sel_addr  = req_address[32*j +: 32];
                    sel_wdata = req_wdata[32*j +: 32];
                    sel_write = req_write[j];
                    sel_csr   = req_address[32*j + CSR_BIT] & CSR_PORT_MASK[j];
                    sel_win   = WINDOW_PORT_MASK[j];
                end
            end
        end
    end

    assign in_window  = ({1'b0, addr_q} >= WinLo) && ({1'b0, addr_q} < WinHi);
    assign rd_pass    = !win_q || in_window;

    assign csr_addr   = addr_q[2];
    assign csr_wdata  = wdata_q;
    assign data_addr  = addr_q[31:2];
    assign data_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            grant_oh_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            csr_q      <= 1'b0;
            win_q      <= 1'b0;
            cnt_q      <= '0;
            req_ack    <= '0;
            req_error  <= '0;
            req_rdata  <= '0;
            csr_read   <= 1'b0;
            csr_write  <= 1'b0;
            data_read  <= 1'b0;
            data_write <= 1'b0;
            busy       <= 1'b0;
        end else begin
            req_ack   <= '0;
            req_error <= '0;
            req_rdata <= '0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_oh_q <= sel_oh;
                        rr_q       <= rr_next;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        write_q    <= sel_write;
                        csr_q      <= sel_csr;
                        win_q      <= sel_win;
                        busy       <= 1'b1;
                        state_q    <= StIssue;
                        if (sel_csr) begin
                            csr_read  <= !sel_write;
                            csr_write <= sel_write;
                        end else begin
                            data_read  <= !sel_write;
                            data_write <= sel_write;
                        end
                    end
                end
                StIssue: begin
                    if (csr_q) begin
                        // CSR port has no waitrequest: one strobe cycle, data valid in it.
                        csr_read  <= 1'b0;
                        csr_write <= 1'b0;
                        req_ack   <= grant_oh_q;
                        if (!write_q) begin
                            req_rdata <= csr_rdata;
                        end
                        state_q <= StDone;
                    end else if (!data_waitrequest) begin
                        data_read  <= 1'b0;
                        data_write <= 1'b0;
                        if (write_q) begin
                            req_ack <= grant_oh_q;
                            state_q <= StDone;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StWaitRead;
                        end
                    end
                end
                StWaitRead: begin
                    if (data_readdatavalid) begin
                        req_ack <= grant_oh_q;
                        if (rd_pass) begin
                            req_rdata <= data_rdata;
                        end
                        state_q <= StDone;
                    end else if (cnt_q >= CntLast) begin
                        cnt_q     <= CntMax;
                        req_ack   <= grant_oh_q;
                        req_error <= grant_oh_q;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_flash_arbiter.sv
// Self-checking bench for n64_flash_arbiter: scoreboard of expected acks, a small
// Avalon flash responder, and one task per scenario.
module tb_n64_flash_arbiter;

    localparam int          NP = 2;
    localparam int unsigned TO = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     req_request;
    logic [NP-1:0]     req_write;
    logic [32*NP-1:0]  req_address;
    logic [32*NP-1:0]  req_wdata;
    logic [NP-1:0]     req_ack;
    logic [NP-1:0]     req_error;
    logic [31:0]       req_rdata;
    logic              csr_addr;
    logic              csr_read;
    logic              csr_write;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;
    logic [29:0]       data_addr;
    logic              data_read;
    logic              data_write;
    logic [31:0]       data_wdata;
    logic [31:0]       data_rdata;
    logic              data_waitrequest;
    logic              data_readdatavalid;
    logic              busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [NP-1:0] ack;
        logic          err;
        logic [31:0]   rdata;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    n64_flash_arbiter #(
        .NUM_PORTS        (NP),
        .CSR_BIT          (27),
        .CSR_PORT_MASK    (8'b10),
        .WINDOW_PORT_MASK (8'b01),
        .WINDOW_BASE      (32'h1000_0000),
        .WINDOW_SIZE      (32'h0001_0000),
        .TIMEOUT          (TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_request        (req_request),
        .req_write          (req_write),
        .req_address        (req_address),
        .req_wdata          (req_wdata),
        .req_ack            (req_ack),
        .req_error          (req_error),
        .req_rdata          (req_rdata),
        .csr_addr           (csr_addr),
        .csr_read           (csr_read),
        .csr_write          (csr_write),
        .csr_wdata          (csr_wdata),
        .csr_rdata          (csr_rdata),
        .data_addr          (data_addr),
        .data_read          (data_read),
        .data_write         (data_write),
        .data_wdata         (data_wdata),
        .data_rdata         (data_rdata),
        .data_waitrequest   (data_waitrequest),
        .data_readdatavalid (data_readdatavalid),
        .busy               (busy)
    );

    task automatic set_req(input int p, input bit wr, input logic [31:0] a,
                           input logic [31:0] d);
        req_write[p]             = wr;
        req_address[32*p +: 32]  = a;
        req_wdata[32*p +: 32]    = d;
        req_request[p]           = 1'b1;
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic wait_strobe(input bit csr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (csr ? (csr_read || csr_write) : (data_read || data_write)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL strobe_wait: no strobe seen within 50 cycles (csr=%0d)", csr);
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (req_ack != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ack_wait: req_ack stayed 0 for 600 cycles");
        end
    endtask

    // Data-port responder: ws stall cycles, then accept; reads answer lat cycles later.
    task automatic serve_data(input int ws, input int lat, input logic [31:0] val,
                              input bit respond);
        bit ok;
        bit was_read;
        wait_strobe(1'b0, ok);
        if (!ok) return;
        was_read = data_read;
        repeat (ws) @(negedge clk);
        data_waitrequest = 1'b0;
        @(negedge clk);
        data_waitrequest = 1'b1;
        if (was_read && respond) begin
            repeat (lat - 1) @(negedge clk);
            data_readdatavalid = 1'b1;
            data_rdata         = val;
            @(negedge clk);
            data_readdatavalid = 1'b0;
            data_rdata         = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ack, req_error, req_rdata, csr_read, csr_write, data_read, data_write, busy}
            !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%b err=%b rdata=%h csr_rw=%b%b data_rw=%b%b busy=%b, want all 0",
                     req_ack, req_error, req_rdata, csr_read, csr_write, data_read, data_write,
                     busy);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || req_ack !== '0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b ack=%b, want 0 0", busy, req_ack);
        end
    endtask

    task automatic test_window_read();
        logic [31:0] addrs [5] = '{32'h1000_0004, 32'h1001_0000, 32'h1000_FFFC,
                                   32'h0FFF_FFFC, 32'h2000_0000};
        logic [31:0] vals  [5] = '{32'hAABB_CCDD, 32'h1234_5678, 32'h5555_AAAA,
                                   32'h7777_8888, 32'h0BAD_CAFE};
        logic [31:0] exps  [5] = '{32'hAABB_CCDD, 32'h0, 32'h5555_AAAA, 32'h0, 32'h0BAD_CAFE};
        int          ports [5] = '{0, 0, 0, 0, 1};
        int          lats  [5] = '{3, 2, 1, 1, 4};
        bit          ok;
        exp_t        e;
        for (int i = 0; i < 5; i++) begin
            set_req(ports[i], 1'b0, addrs[i], 32'h0);
            sb.push_back('{ack: onehot(ports[i]), err: 1'b0, rdata: exps[i]});
            wait_strobe(1'b0, ok);
            total++;
            if (data_read !== 1'b1 || csr_read !== 1'b0 || data_addr !== addrs[i][31:2]) begin
                bad++;
                $display("FAIL win_issue[%0d]: data_read=%b csr_read=%b data_addr=%h, want 1 0 %h",
                         i, data_read, csr_read, data_addr, addrs[i][31:2]);
            end
            serve_data(0, lats[i], vals[i], 1'b1);
            wait_ack(ok);
            e = sb.pop_front();
            total++;
            if (req_ack !== e.ack || req_error !== e.err || req_rdata !== e.rdata) begin
                bad++;
                $display("FAIL win_ack[%0d]: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                         i, req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
            end
            req_request[ports[i]] = 1'b0;
            @(negedge clk);
            total++;
            if (req_ack !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL win_ack_pulse[%0d]: ack=%b busy=%b, want 0 0", i, req_ack, busy);
            end
        end
    endtask

    // The previous scenario last granted port 1, so the pointer sits at 0.
    task automatic test_round_robin();
        logic [31:0] a0 = 32'h1000_0100;
        logic [31:0] a1 = 32'h0000_0200;
        logic [31:0] want_addr;
        logic [31:0] val;
        bit          ok;
        exp_t        e;
        set_req(0, 1'b0, a0, 32'h0);
        set_req(1, 1'b0, a1, 32'h0);
        for (int k = 0; k < 6; k++) begin
            val       = 32'hA000_0000 + 32'(k);
            want_addr = (k % 2 == 0) ? a0 : a1;
            sb.push_back('{ack: onehot(k % 2), err: 1'b0, rdata: val});
            wait_strobe(1'b0, ok);
            total++;
            if (data_addr !== want_addr[31:2]) begin
                bad++;
                $display("FAIL rr_grant[%0d]: data_addr=%h, want %h", k, data_addr,
                         want_addr[31:2]);
            end
            serve_data(k % 2, 1 + (k % 3), val, 1'b1);
            wait_ack(ok);
            e = sb.pop_front();
            total++;
            if (req_ack !== e.ack || req_error !== e.err || req_rdata !== e.rdata) begin
                bad++;
                $display("FAIL rr_ack[%0d]: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                         k, req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
            end
        end
        req_request = '0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_drain: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_csr();
        bit   ok;
        exp_t e;
        // Port 1 CSR write: strobe in the cycle after the request, ack one cycle later.
        set_req(1, 1'b1, 32'h0800_0000, 32'h5);
        sb.push_back('{ack: onehot(1), err: 1'b0, rdata: 32'h0});
        @(negedge clk);
        total++;
        if (csr_write !== 1'b1 || csr_read !== 1'b0 || csr_addr !== 1'b0 ||
            csr_wdata !== 32'h5 || data_write !== 1'b0) begin
            bad++;
            $display("FAIL csr_write_strobe: csr_w=%b csr_r=%b csr_addr=%b wdata=%h data_w=%b, want 1 0 0 5 0",
                     csr_write, csr_read, csr_addr, csr_wdata, data_write);
        end
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (csr_write !== 1'b0 || req_ack !== e.ack || req_error !== e.err ||
            req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL csr_write_ack: csr_w=%b ack=%b err=%b rdata=%h, want 0 %b %b %h",
                     csr_write, req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
        end
        req_request[1] = 1'b0;
        @(negedge clk);
        // Port 1 CSR read of register 1.
        csr_rdata = 32'hCAFE_0001;
        set_req(1, 1'b0, 32'h0800_0004, 32'h0);
        sb.push_back('{ack: onehot(1), err: 1'b0, rdata: 32'hCAFE_0001});
        @(negedge clk);
        total++;
        if (csr_read !== 1'b1 || csr_addr !== 1'b1 || data_read !== 1'b0) begin
            bad++;
            $display("FAIL csr_read_strobe: csr_r=%b csr_addr=%b data_r=%b, want 1 1 0",
                     csr_read, csr_addr, data_read);
        end
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (csr_read !== 1'b0 || req_ack !== e.ack || req_error !== e.err ||
            req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL csr_read_ack: csr_r=%b ack=%b err=%b rdata=%h, want 0 %b %b %h",
                     csr_read, req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
        end
        req_request[1] = 1'b0;
        csr_rdata      = '0;
        @(negedge clk);
        // Port 0 has no CSR access: same address lands on the data port.
        set_req(0, 1'b1, 32'h0800_0000, 32'h5);
        sb.push_back('{ack: onehot(0), err: 1'b0, rdata: 32'h0});
        wait_strobe(1'b0, ok);
        total++;
        if (data_write !== 1'b1 || csr_write !== 1'b0 || data_addr !== 30'h0200_0000 ||
            data_wdata !== 32'h5) begin
            bad++;
            $display("FAIL csr_masked: data_w=%b csr_w=%b data_addr=%h wdata=%h, want 1 0 02000000 5",
                     data_write, csr_write, data_addr, data_wdata);
        end
        serve_data(2, 0, 32'h0, 1'b1);
        wait_ack(ok);
        e = sb.pop_front();
        total++;
        if (req_ack !== e.ack || req_error !== e.err || req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL csr_masked_ack: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                     req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
        end
        req_request[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit   ok;
        int   cyc;
        bit   stray;
        exp_t e;
        set_req(0, 1'b0, 32'h1000_0008, 32'h0);
        sb.push_back('{ack: onehot(0), err: 1'b1, rdata: 32'h0});
        serve_data(0, 0, 32'h0, 1'b0);
        // Now in the first cycle after the accept edge.
        cyc = 1;
        while (req_ack == '0 && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != int'(TO) + 1) begin
            bad++;
            $display("FAIL timeout_cycles: ack after %0d cycles, want %0d", cyc, TO + 1);
        end
        e = sb.pop_front();
        total++;
        if (req_ack !== e.ack || req_error !== e.err || req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL timeout_ack: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                     req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
        end
        req_request[0] = 1'b0;
        @(negedge clk);
        data_readdatavalid = 1'b1;
        data_rdata         = 32'hDEAD_BEEF;
        @(negedge clk);
        data_readdatavalid = 1'b0;
        data_rdata         = '0;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (req_ack !== '0 || busy !== 1'b0) stray = 1'b1;
            @(negedge clk);
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL late_valid: stray ack/busy after late readdatavalid, want none");
        end
        set_req(1, 1'b0, 32'h0000_0040, 32'h0);
        sb.push_back('{ack: onehot(1), err: 1'b0, rdata: 32'h0BAD_F00D});
        serve_data(1, 2, 32'h0BAD_F00D, 1'b1);
        wait_ack(ok);
        e = sb.pop_front();
        total++;
        if (req_ack !== e.ack || req_error !== e.err || req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL after_timeout: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                     req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
        end
        req_request[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        bit   ok;
        bit   stray;
        exp_t e;
        // Port 0 grant leaves the pointer at 1; reset must bring it back to 0.
        set_req(0, 1'b0, 32'h1000_0010, 32'h0);
        wait_strobe(1'b0, ok);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (data_read !== 1'b0 || busy !== 1'b0 || req_ack !== '0) begin
            bad++;
            $display("FAIL reset_async: data_read=%b busy=%b ack=%b, want 0 0 0",
                     data_read, busy, req_ack);
        end
        req_request = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (req_ack !== '0 || busy !== 1'b0 || data_read !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL reset_no_ack: activity after aborted access, want none");
        end
        set_req(0, 1'b0, 32'h1000_0020, 32'h0);
        set_req(1, 1'b0, 32'h0000_0300, 32'h0);
        sb.push_back('{ack: onehot(0), err: 1'b0, rdata: 32'h1111_2222});
        wait_strobe(1'b0, ok);
        total++;
        if (data_addr !== 30'h0400_0008) begin
            bad++;
            $display("FAIL rr_after_reset: data_addr=%h, want 04000008", data_addr);
        end
        serve_data(0, 1, 32'h1111_2222, 1'b1);
        wait_ack(ok);
        e = sb.pop_front();
        total++;
        if (req_ack !== e.ack || req_error !== e.err || req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL reset_first: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                     req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
        end
        req_request[0] = 1'b0;
        sb.push_back('{ack: onehot(1), err: 1'b0, rdata: 32'h3333_4444});
        serve_data(0, 2, 32'h3333_4444, 1'b1);
        wait_ack(ok);
        e = sb.pop_front();
        total++;
        if (req_ack !== e.ack || req_error !== e.err || req_rdata !== e.rdata) begin
            bad++;
            $display("FAIL reset_second: ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                     req_ack, req_error, req_rdata, e.ack, e.err, e.rdata);
        end
        req_request[1] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        req_request        = '0;
        req_write          = '0;
        req_address        = '0;
        req_wdata          = '0;
        csr_rdata          = '0;
        data_rdata         = '0;
        data_waitrequest   = 1'b1;
        data_readdatavalid = 1'b0;
        test_reset();
        test_window_read();
        test_round_robin();
        test_csr();
        test_timeout();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/n64_flash_arbiter.md
Name: n64_flash_arbiter

Overview:
- Parametrised successor to the single-N64/single-CPU flash access path.
- Arbitrates NUM_PORTS requesters onto one on-chip flash controller, which has an Avalon-MM CSR port and an Avalon-MM data port.
- Uses round-robin priority and a per-port CSR access mask.
- Has a read-timeout watchdog and optional read-window gating per port.
- Sits between the N64 bus / CPU flash interfaces and the flash IP.

Parameters:
- NUM_PORTS, 2: number of requesters; range 1..8.
- CSR_BIT, 27: address bit that selects the CSR port over the data port.
- CSR_PORT_MASK, 'b10: bit i=1 means port i may reach CSR. Otherwise bit CSR_BIT is ignored and the access goes to data.
- WINDOW_PORT_MASK, 'b01: bit i=1 means port i reads return data only inside the window.
- WINDOW_BASE, 32'h1000_0000: inclusive start of the read window.
- WINDOW_SIZE, 32'h0001_0000: window length in bytes.
- TIMEOUT, 255: maximum cycles allowed from read issue to readdatavalid. Range 1..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_request  in  NUM_PORTS  per-port request pulse or level.
- req_write  in  NUM_PORTS  per-port write flag.
- req_address  in  32*NUM_PORTS  per-port byte address; port i occupies [32i+31:32i].
- req_wdata  in  32*NUM_PORTS  per-port write data.
- req_ack  out  NUM_PORTS  one-cycle completion pulse, only to the granted port.
- req_error  out  NUM_PORTS  asserted with req_ack on timeout.
- req_rdata  out  32  read data; valid only in the req_ack cycle, 0 otherwise.
- csr_addr  out  1  address[2].
- csr_read, csr_write  out  1  CSR strobes.
- csr_wdata  out  32  CSR write data.
- csr_rdata  in  32  CSR read data.
- data_addr  out  30  address[31:2].
- data_read, data_write  out  1  data strobes.
- data_wdata  out  32  data write data.
- data_rdata  in  32  data read data.
- data_waitrequest  in  1  data port stall.
- data_readdatavalid  in  1  data port read valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert at the clk edge):
  - State=IDLE, rr pointer=0, all strobes 0, req_ack=0, req_error=0, req_rdata=0, busy=0.
  - Reset mid-transaction drops the strobes immediately. No ack is issued for the aborted access.
- Latches: address, wdata, write and grant index are captured at grant and held until the return to IDLE.
- IDLE:
  - Pick the first requesting port at or after the rr pointer (modulo NUM_PORTS).
  - Latch that port's fields, set rr pointer = grant+1 (wrap to 0), go to ISSUE.
  - No request: stay in IDLE.
- Target select: CSR when latched address[CSR_BIT]=1 AND CSR_PORT_MASK[grant]=1; otherwise data.
- ISSUE, CSR target:
  - Assert csr_read or csr_write for exactly one cycle.
  - Next cycle: pulse req_ack; for a read, req_rdata=csr_rdata. Return to IDLE.
  - Fixed latency of 2 cycles from grant.
- ISSUE, data target:
  - Hold data_read or data_write until a cycle with data_waitrequest=0. That cycle is the accept.
  - Write accept: the next cycle pulses req_ack, then IDLE.
  - Read accept: drop data_read, go to WAIT_READ, clear the timeout counter.
- WAIT_READ:
  - Counter increments each cycle.
  - data_readdatavalid=1: pulse req_ack, req_rdata=data_rdata gated by the window rule, then IDLE.
  - Counter reaches TIMEOUT first: pulse req_ack and req_error, req_rdata=0, then IDLE.
  - A late readdatavalid that arrives in IDLE is discarded.
- Window rule: if WINDOW_PORT_MASK[grant]=1 and the address is outside [WINDOW_BASE, WINDOW_BASE+WINDOW_SIZE), req_rdata=0. The comparison is 33-bit to avoid wrap-around.
- Handshake constraints:
  - Only one transaction is outstanding at a time.
  - The requester holds its fields stable until granted.
  - Requests arriving while busy wait; none are lost while held high.
  - A request asserted in the same cycle as an ack is eligible in the very next IDLE cycle.
- Simultaneous requests: rr order guarantees no port waits more than NUM_PORTS-1 transactions.
- The timeout counter saturates; it never wraps.

Test Plan:
- Port0 reads 0x1000_0004, flash returns 0xAABBCCDD after 3 cycles -> port0 req_ack 1 cycle, req_rdata=0xAABBCCDD, req_error=0.
- Port0 reads 0x1001_0000 (outside window), flash returns 0x12345678 -> req_ack with req_rdata=0.
- Ports 0 and 1 request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 with no back-to-back repeat.
- Port1 writes 0x0800_0000 (CSR bit set), wdata 0x5 -> csr_write pulses 1 cycle with csr_addr=0, req_ack 1 cycle later. The same address from port0 -> data_write instead.
- Data read where readdatavalid never comes, TIMEOUT=255 -> req_ack and req_error at counter 255, rdata=0. An injected late readdatavalid is ignored, and the next request completes normally.
- reset asserted while data_read is stalled by waitrequest -> data_read=0 asynchronously, no req_ack, and the arbiter is in IDLE with rr=0 after release.
